// File: rtl/conv_narrow_to_wide_if.sv
// Stream bus for the narrow-to-wide converter: narrow source side plus packed sink side.
// flush_in exists only when CONV_FLUSH_EN is defined.
interface conv_narrow_to_wide_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 3
);
    localparam int CW = $clog2(RATIO + 1);

    logic [IN_WIDTH-1:0]       data_in;
    logic                      valid_in;
    logic                      ready_out;
    logic [IN_WIDTH*RATIO-1:0] data_out;
    logic                      valid_out;
    logic                      ready_in;
    logic [CW-1:0]             count_out;
`ifdef CONV_FLUSH_EN
    logic                      flush_in;

    modport master (output data_in, valid_in, ready_in, flush_in,
                    input  ready_out, data_out, valid_out, count_out);
    modport slave  (input  data_in, valid_in, ready_in, flush_in,
                    output ready_out, data_out, valid_out, count_out);
`else
    modport master (output data_in, valid_in, ready_in,
                    input  ready_out, data_out, valid_out, count_out);
    modport slave  (input  data_in, valid_in, ready_in,
                    output ready_out, data_out, valid_out, count_out);
`endif
endinterface

// File: rtl/conv_narrow_to_wide.sv
// Packs RATIO narrow beats into one wide word; the last beat passes through combinationally.
// Optional partial-word flush is enabled by defining CONV_FLUSH_EN.
module conv_narrow_to_wide #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                  clk_in,
    input logic                  reset_in,
    conv_narrow_to_wide_if.slave bus
);
    localparam int IDXW = $clog2(RATIO);
    localparam int CW   = $clog2(RATIO + 1);
    localparam logic [IDXW-1:0] LAST = IDXW'(RATIO - 1);

    logic [IDXW-1:0]                idx;
    logic [RATIO-2:0][IN_WIDTH-1:0] lane_q;
    logic [RATIO-1:0][IN_WIDTH-1:0] lane_w;
    logic                           final_st;
    logic                           flush_act;

    assign final_st = (idx == LAST);

    // A full word in the final state wins over a pending flush.
`ifdef CONV_FLUSH_EN
    assign flush_act = bus.flush_in && (idx != '0) && !(final_st && bus.valid_in);
`else
    assign flush_act = 1'b0;
`endif

    always_comb begin
        bus.valid_out = final_st & bus.valid_in;
        bus.ready_out = final_st ? bus.ready_in : 1'b1;
        bus.count_out = CW'(RATIO);
        if (flush_act) begin
            bus.valid_out = 1'b1;
            bus.ready_out = 1'b0;
            bus.count_out = CW'(idx);
        end
    end

    always_comb begin
        for (int k = 0; k < RATIO - 1; k++) lane_w[k] = lane_q[k];
        lane_w[RATIO-1] = bus.data_in;
        if (flush_act) begin
            for (int k = 0; k < RATIO; k++)
                if (k >= int'(idx)) lane_w[k] = '0;
        end
    end

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        localparam int POS = MSB_FIRST ? (RATIO - 1 - k) : k;
        assign bus.data_out[POS*IN_WIDTH +: IN_WIDTH] = lane_w[k];
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            idx    <= '0;
            lane_q <= '0;
        end else if (flush_act) begin
            if (bus.ready_in) idx <= '0;
        end else if (final_st) begin
            if (bus.valid_in && bus.ready_in) idx <= '0;
        end else if (bus.valid_in) begin
            for (int k = 0; k < RATIO - 1; k++)
                if (idx == IDXW'(k)) lane_q[k] <= bus.data_in;
            idx <= idx + 1'b1;
        end
    end
endmodule

// File: doc/conv_narrow_to_wide.md
# conv_narrow_to_wide

Parametrised narrow-to-wide stream width converter for the DVR connector set. It packs RATIO consecutive IN_WIDTH-bit beats from a valid/ready source into one IN_WIDTH*RATIO-bit word on a valid/ready sink. The packing adds no latency: the last beat passes through combinationally. It adds configurable lane order and an optional flush that emits a partial word, so a stream whose length is not a multiple of RATIO can be drained.

## Interface
- IN_WIDTH, default 8: width of one input beat; must be ≥1.
- RATIO, default 3: input beats per output word; must be ≥2.
- MSB_FIRST, default 1: 1 puts the first beat in the most-significant lane; 0 puts it in the least-significant lane.
- clk_in  in  1  clock; all state changes on its rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- data_in  in  IN_WIDTH  input beat.
- valid_in  in  1  input beat valid.
- ready_out  out  1  converter can accept an input beat.
- data_out  out  IN_WIDTH*RATIO  packed word.
- valid_out  out  1  packed word valid.
- ready_in  in  1  sink accepts the word.
- count_out  out  $clog2(RATIO+1)  number of filled lanes in the current word; meaningful only while valid_out=1.
- flush_in  in  1  request emission of a partial word; port exists only with CONV_FLUSH_EN.

## Operation
- State is a beat index idx in the range 0..RATIO-1, plus RATIO-1 lane registers holding beats 0..RATIO-2.
- Lane k holds the k-th beat of a word.
  - MSB_FIRST=1: lane k occupies bits [(RATIO-k)*IN_WIDTH-1 : (RATIO-1-k)*IN_WIDTH].
  - MSB_FIRST=0: lane k occupies bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- Filling state (idx < RATIO-1):
  - ready_out=1 and valid_out=0. ready_in is ignored.
  - If valid_in=1, the beat is stored in lane idx and idx increments.
- Final state (idx = RATIO-1):
  - ready_out=ready_in and valid_out=valid_in.
  - data_out is the stored lanes with data_in in lane RATIO-1; count_out=RATIO.
  - When valid_in and ready_in are both high, the word transfers and idx returns to 0.
  - Otherwise idx holds, and the stored lanes are not altered.
- Steady state with valid_in=ready_in=1 gives one output word every RATIO cycles (duty cycle 1/RATIO).
- data_out is don't-care while valid_out=0.

## Timing
- Reset: idx=0, all lane registers 0, ready_out=1, valid_out=0. Reset applies immediately and asynchronously.
- Reset mid-word discards the partial word. No output results from it.
- Latency from last input beat to output word: 0 cycles (combinational).
- Combinational paths: ready_in→ready_out and valid_in→valid_out in the final state; data_in→data_out at all times.
- Valid never depends on ready. No combinational loop exists if the sink complies with this rule.
- A beat is consumed only on a clock edge where valid_in=1 and ready_out=1.

## Configuration
- CONV_FLUSH_EN defined: the flush_in port exists. When flush_in=1 and idx≥1:
  - In the filling state, or in the final state with valid_in=0: valid_out=1 and ready_out=0.
  - The word carries the stored lanes 0..idx-1; all unfilled lanes are zero. count_out=idx.
  - When ready_in=1, the partial word transfers and idx returns to 0.
  - flush_in must stay high until the partial word transfers.
  - Final state with valid_in=1: a full word takes precedence and the flush is ignored.
  - flush_in with idx=0 has no effect.
- CONV_FLUSH_EN undefined: no flush_in port, no partial words, and count_out reads RATIO whenever valid_out=1.

## Test plan
- Basic packing, IN_WIDTH=8, RATIO=3, MSB_FIRST=1, ready_in=1:
  - Input beats 12, 34, 56 → data_out=123456 with valid_out=1 and count_out=3 in the cycle of the third beat.
  - valid_out=0 during the first two beats.
- Ready and valid checks in each state:
  - While filling, ready_in=0 with valid_in=1 → beats 78 and 9A are still accepted, and ready_out=1.
  - In the final state with data_in=BC, valid_in/ready_in set to 0/0, 0/1, 1/0 → no transfer, and ready_out follows ready_in.
  - valid_in=1, ready_in=1 → data_out=789ABC, valid_out=1.
- Steady state: 12 back-to-back beats 12..78 with all handshakes high → four words 123456, 789ABC, DEF012, 345678, on cycles 3, 6, 9, 12.
- Lane order, MSB_FIRST=0, RATIO=4: beats 11, 22, 33, 44 → data_out=44332211.
- Flush (CONV_FLUSH_EN, RATIO=3, MSB_FIRST=1):
  - Beat AB, then flush_in=1 with ready_in=0 for 2 cycles → valid_out=1 and data_out=AB0000 with count_out=1 held for both cycles.
  - Then ready_in=1 → the word transfers and idx=0.
  - A following beat sequence 01, 02, 03 → data_out=010203.
- Reset after two beats (reset_in pulsed asynchronously between clock edges) → valid_out=0 immediately. Next beats C1, C2, C3 → data_out=C1C2C3.
